rram_cell_driver: RTL and testbench
===================================

Name: rram_cell_driver

Overview:
Digital sequencer that drives one RRAM cell column: word-line enable, bit-line SET pulse, bit-line BACK pulse, Dback and select-line enable.
- Converts a command (RESET / SET with weight code / READ / BACK) into timed pin levels that the analog cell interprets.
- SET pulse width in clock cycles equals the weight code, so the programmed conductance is proportional to the weight. With a 10 ns clk, each cycle adds 0.1 of cell current.
- Sits between the training controller and the analog array's level shifters.

Parameters:
WW, 8, weight code width; SET pulse length = weight cycles (0..2^WW-1)
SETUP_CYC, 2, cycles wl must be high before bl SET pulse rises
HOLD_CYC, 2, cycles after bl SET pulse falls before done
READ_CYC, 4, cycles sl_en held for a READ
BACK_CYC, 3, cycles bl_back_en held for a BACK
RESET_CYC, 4, cycles wl held low for a RESET

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  driver can accept command (high only in IDLE)
cmd_op  in  2  0=RESET, 1=SET, 2=READ, 3=BACK
cmd_weight  in  WW  SET pulse length in cycles (ignored for other ops)
done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse, coincident with done, for an illegal command
wl_en  out  1  word line high (cell on mode); low resets the cell
bl_set_en  out  1  bit line driven above the SET threshold
bl_back_en  out  1  bit line driven to the BACK level (between BACK and SET thresholds)
dback  out  1  back-propagation enable to the cell
sl_en  out  1  select-line input applied (forward read)
adc_sample  out  1  one-cycle strobe on the last sl_en cycle
wl_state  out  1  registered copy of wl_en, for the controller

Behaviour:
- Reset (async): all outputs 0, state IDLE, counter 0. Reset mid-operation drops wl_en immediately; this equals a cell reset and is legal.
- All outputs are registered. bl_set_en and bl_back_en are never both high. No bl enable is high while wl_en is low.
- Handshake: a command is accepted when cmd_valid && cmd_ready. Op and weight are latched on that cycle. cmd_ready is low from the next cycle until the cycle after done.
- States: IDLE, SETUP, PULSE, HOLD, READ, BACK_ARM, BACK_PULSE, RST_LOW, FIN.
- SET: wl_en rises the cycle after accept (SETUP) and is held SETUP_CYC cycles. If wl_en was already high, it stays high and SETUP still runs.
  - PULSE: bl_set_en high for exactly cmd_weight cycles. Weight 0 skips PULSE.
  - HOLD: HOLD_CYC cycles, then FIN. wl_en stays high after SET.
  - A SET on an already-programmed cell overwrites it; no error.
- READ: legal only if wl_state=1. sl_en high READ_CYC cycles; adc_sample pulses on the last one; then FIN.
- BACK: legal only if wl_state=1.
  - BACK_ARM: dback high for 1 cycle before the edge.
  - BACK_PULSE: bl_back_en high BACK_CYC cycles with dback held, so the cell sees its rising BACK-threshold crossing with Dback asserted.
  - dback falls together with bl_back_en, then FIN.
- READ or BACK with wl_state=0: no pin toggles; FIN the cycle after accept with err=1.
- RESET: wl_en low for RESET_CYC cycles (RST_LOW), then FIN. wl_en remains low afterwards. RESET while already off is legal.
- FIN: done=1 for one cycle, then IDLE.
- Latency, accept to done:
  - SET: SETUP_CYC + weight + HOLD_CYC + 1
  - READ: READ_CYC + 1
  - BACK: 1 + BACK_CYC + 1
  - RESET: RESET_CYC + 1
- Counter: a down-counter of width max(WW, clog2 of largest *_CYC)+1, loaded on state entry. It must handle weight = 2^WW-1 without wrap.
- cmd_valid while busy is ignored; the controller holds it until ready.

Decomposition:
- Package rram_drv_pkg holds:
  - op encoding enum (OP_RESET, OP_SET, OP_READ, OP_BACK)
  - state enum
  - counter-width function
- One natural sub-module, rram_pulse_timer: a loadable down-counter with a zero flag, reused for every timed state.

Test Plan:
- Power-up reset, then SET weight=5 (defaults) -> wl_en rises cycle 1, bl_set_en high exactly cycles 3-7, done at cycle 10, wl_en stays 1.
- SET weight=0 -> no bl_set_en pulse, done 5 cycles after accept; SET weight=255 -> bl_set_en high exactly 255 cycles.
- READ after SET -> sl_en high 4 cycles, adc_sample on the 4th, done next cycle; READ after RESET -> err=done=1 the cycle after accept, sl_en never high.
- BACK after SET -> dback rises 1 cycle before bl_back_en, bl_back_en high 3 cycles, both fall together, done next cycle.
- RESET -> wl_en low 4 cycles, done; then SET raises wl_en again. Assert rst mid-PULSE -> all outputs 0 asynchronously, cmd_ready=1 after release.
- cmd_valid held through a busy SET with a second command -> second command accepted only on the cycle after done; bl_set_en && bl_back_en never both 1 (assertion).

Source files
------------

// File: rtl/rram_drv_pkg.sv
// Shared types and helpers for the RRAM cell driver.
//   op_e       : command opcode encoding seen on cmd_op
//   state_e    : sequencer states
//   cnt_width  : width of the shared down-counter
package rram_drv_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_SET   = 2'd1,
        OP_READ  = 2'd2,
        OP_BACK  = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StRead,
        StBackArm,
        StBackPulse,
        StRstLow,
        StFin
    } state_e;

    // One spare bit beyond max(ww, clog2(max_cyc)) so a full-scale weight never wraps.
    function automatic int unsigned cnt_width(input int unsigned ww, input int unsigned max_cyc);
        int unsigned cw;
        cw = $clog2(max_cyc);
        return ((ww > cw) ? ww : cw) + 1;
    endfunction

endpackage

// File: rtl/rram_pulse_timer.sv
// Loadable down-counter shared by every timed state of the driver.
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : load load_val_i this cycle (takes priority over counting)
//   load_val_i  : value to load (state duration minus one)
//   zero_o      : current count is zero (last cycle of the running state)
//   last_o      : count will be zero next cycle
module rram_pulse_timer #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_d == '0);

endmodule

// File: rtl/rram_cell_driver.sv
// Sequencer driving one RRAM cell column (word line, bit-line SET/BACK, Dback, select line).
//   clk, rst              : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_op, cmd_weight    : opcode and SET pulse length in cycles
//   done, err             : completion pulse; err marks an illegal READ/BACK
//   wl_en, bl_set_en, bl_back_en, dback, sl_en : registered cell pin levels
//   adc_sample            : strobe on the last sl_en cycle
//   wl_state              : registered copy of wl_en
module rram_cell_driver
    import rram_drv_pkg::*;
#(
    parameter int unsigned WW        = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned READ_CYC  = 4,
    parameter int unsigned BACK_CYC  = 3,
    parameter int unsigned RESET_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [WW-1:0] cmd_weight,
    output logic          done,
    output logic          err,
    output logic          wl_en,
    output logic          bl_set_en,
    output logic          bl_back_en,
    output logic          dback,
    output logic          sl_en,
    output logic          adc_sample,
    output logic          wl_state
);

    localparam int unsigned MaxAB  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MaxCD  = (READ_CYC > BACK_CYC) ? READ_CYC : BACK_CYC;
    localparam int unsigned MaxABC = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned MaxCyc = (MaxABC > RESET_CYC) ? MaxABC : RESET_CYC;
    localparam int unsigned CntW   = cnt_width(WW, MaxCyc);

    state_e        state_q, state_d;
    logic [WW-1:0] weight_q, weight_d;

    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_zero, tmr_last;
    logic            accept;

    logic cmd_ready_q, cmd_ready_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic wl_en_q, wl_en_d;
    logic bl_set_en_q, bl_set_en_d;
    logic bl_back_en_q, bl_back_en_d;
    logic dback_q, dback_d;
    logic sl_en_q, sl_en_d;
    logic adc_sample_q, adc_sample_d;
    logic wl_state_q, wl_state_d;

    rram_pulse_timer #(
        .Width(CntW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .zero_o    (tmr_zero),
        .last_o    (tmr_last)
    );

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        err_d    = 1'b0;
        accept   = cmd_valid && cmd_ready_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    weight_d = cmd_weight;
                    case (op_e'(cmd_op))
                        OP_SET: begin
                            state_d  = StSetup;
                            tmr_load = 1'b1;
                            tmr_val  = CntW'(SETUP_CYC - 1);
                        end
                        OP_READ: begin
                            if (wl_state_q) begin
                                state_d  = StRead;
                                tmr_load = 1'b1;
                                tmr_val  = CntW'(READ_CYC - 1);
                            end else begin
                                state_d = StFin;
                                err_d   = 1'b1;
                            end
                        end
                        OP_BACK: begin
                            if (wl_state_q) begin
                                state_d = StBackArm;
                            end else begin
                                state_d = StFin;
                                err_d   = 1'b1;
                            end
                        end
                        default: begin
                            state_d  = StRstLow;
                            tmr_load = 1'b1;
                            tmr_val  = CntW'(RESET_CYC - 1);
                        end
                    endcase
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (weight_q != '0) begin
                        state_d = StPulse;
                        tmr_val = CntW'(weight_q) - CntW'(1);
                    end else begin
                        state_d = StHold;
                        tmr_val = CntW'(HOLD_CYC - 1);
                    end
                end
            end
            StPulse: begin
                if (tmr_zero) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(HOLD_CYC - 1);
                end
            end
            StBackArm: begin
                state_d  = StBackPulse;
                tmr_load = 1'b1;
                tmr_val  = CntW'(BACK_CYC - 1);
            end
            StHold, StRead, StBackPulse, StRstLow: begin
                if (tmr_zero) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Pins are decoded from the next state so each registered pin lines up with its state.
        cmd_ready_d  = (state_d == StIdle);
        done_d       = (state_d == StFin);
        bl_set_en_d  = (state_d == StPulse);
        bl_back_en_d = (state_d == StBackPulse);
        dback_d      = (state_d == StBackArm) || (state_d == StBackPulse);
        sl_en_d      = (state_d == StRead);
        adc_sample_d = (state_d == StRead) && tmr_last;
        wl_state_d   = wl_en_q;

        // Word line is sticky: SET leaves it on, RESET leaves it off.
        if ((state_d == StSetup) || (state_d == StPulse) || (state_d == StHold)) begin
            wl_en_d = 1'b1;
        end else if (state_d == StRstLow) begin
            wl_en_d = 1'b0;
        end else begin
            wl_en_d = wl_en_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            weight_q     <= '0;
            cmd_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wl_en_q      <= 1'b0;
            bl_set_en_q  <= 1'b0;
            bl_back_en_q <= 1'b0;
            dback_q      <= 1'b0;
            sl_en_q      <= 1'b0;
            adc_sample_q <= 1'b0;
            wl_state_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            weight_q     <= weight_d;
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wl_en_q      <= wl_en_d;
            bl_set_en_q  <= bl_set_en_d;
            bl_back_en_q <= bl_back_en_d;
            dback_q      <= dback_d;
            sl_en_q      <= sl_en_d;
            adc_sample_q <= adc_sample_d;
            wl_state_q   <= wl_state_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign wl_en      = wl_en_q;
    assign bl_set_en  = bl_set_en_q;
    assign bl_back_en = bl_back_en_q;
    assign dback      = dback_q;
    assign sl_en      = sl_en_q;
    assign adc_sample = adc_sample_q;
    assign wl_state   = wl_state_q;

endmodule

// File: tb/tb_rram_cell_driver.sv
// Self-checking bench for rram_cell_driver: directed steps followed by random commands,
// each compared cycle by cycle against timing derived from the command rules.
module tb_rram_cell_driver;

    localparam int S  = 2;  // SETUP_CYC
    localparam int H  = 2;  // HOLD_CYC
    localparam int R  = 4;  // READ_CYC
    localparam int B  = 3;  // BACK_CYC
    localparam int RC = 4;  // RESET_CYC
    localparam int NR = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_weight;
    logic       done, err, wl_en, bl_set_en, bl_back_en, dback, sl_en, adc_sample, wl_state;
    logic [9:0] obs_vec;

    int total = 0;
    int bad   = 0;
    bit cell_on;

    int rop [NR];
    int rw  [NR];
    bit rh  [NR];

    rram_cell_driver dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_weight(cmd_weight),
        .done      (done),
        .err       (err),
        .wl_en     (wl_en),
        .bl_set_en (bl_set_en),
        .bl_back_en(bl_back_en),
        .dback     (dback),
        .sl_en     (sl_en),
        .adc_sample(adc_sample),
        .wl_state  (wl_state)
    );

    always #5 clk = ~clk;

    // {ready, done, err, wl_en, bl_set, bl_back, dback, sl_en, adc, wl_state}
    assign obs_vec = {cmd_ready, done, err, wl_en, bl_set_en, bl_back_en, dback, sl_en,
                      adc_sample, wl_state};

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Word-line level k cycles after accept.
    function automatic bit exp_wl(input int op, input int k);
        if (k <= 0) return cell_on;
        if (op == 1) return 1'b1;
        if (op == 0) return 1'b0;
        return cell_on;
    endfunction

    function automatic logic [9:0] exp_vec(input int op, input int w, input bit legal,
                                           input int lat, input int k);
        bit rdy, dn, er, wl, bs, bb, db, sl, adc, ws;
        rdy = (k > lat);
        dn  = (k == lat);
        er  = (k == lat) && !legal;
        wl  = exp_wl(op, k);
        ws  = exp_wl(op, k - 1);
        bs  = (op == 1) && (k >= S + 1) && (k <= S + w);
        bb  = (op == 3) && legal && (k >= 2) && (k <= B + 1);
        db  = (op == 3) && legal && (k >= 1) && (k <= B + 1);
        sl  = (op == 2) && legal && (k >= 1) && (k <= R);
        adc = (op == 2) && legal && (k == R);
        return {rdy, dn, er, wl, bs, bb, db, sl, adc, ws};
    endfunction

    // Issue one command from a negedge; with hold set, cmd_valid stays high presenting the
    // next command while busy, so it must be taken only on the cycle after done.
    task automatic run_cmd(input int op, input int w, input bit hold, input int nop,
                           input int nw);
        int  lat;
        int  waits;
        bit  legal;
        cmd_op     = 2'(op);
        cmd_weight = 8'(w);
        cmd_valid  = 1'b1;
        waits = 0;
        while (cmd_ready !== 1'b1 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout op=%0d observed_ready=%b expected_ready=1", op, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        legal = (op == 0 || op == 1) ? 1'b1 : cell_on;
        case (op)
            1:       lat = S + w + H + 1;
            2:       lat = legal ? R + 1 : 1;
            3:       lat = legal ? B + 2 : 1;
            default: lat = RC + 1;
        endcase
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check($sformatf("op%0d_w%0d_k%0d", op, w, k), obs_vec, exp_vec(op, w, legal, lat, k));
            if (k == 1) begin
                if (hold) begin
                    cmd_op     = 2'(nop);
                    cmd_weight = 8'(nw);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        if (op == 1) cell_on = 1'b1;
        else if (op == 0) cell_on = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            total++;
            assert (!(bl_set_en && bl_back_en)) else begin
                bad++;
                $error("FAIL bl_exclusive observed_set=%b observed_back=%b expected=not_both",
                       bl_set_en, bl_back_en);
            end
            total++;
            assert (!((bl_set_en || bl_back_en) && !wl_en)) else begin
                bad++;
                $error("FAIL bl_without_wl observed_wl=%b expected_wl=1", wl_en);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_weight = 8'd0;
        cell_on    = 1'b0;
        #2;
        check("reset_outputs", obs_vec, 10'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", obs_vec, 10'b10_0000_0000);

        // Directed sequence
        run_cmd(1, 5, 1'b0, 0, 0);    // SET 5
        run_cmd(1, 0, 1'b0, 0, 0);    // SET 0, no pulse
        run_cmd(1, 255, 1'b0, 0, 0);  // SET full scale
        run_cmd(2, 0, 1'b0, 0, 0);    // READ legal
        run_cmd(3, 0, 1'b0, 0, 0);    // BACK legal
        run_cmd(0, 0, 1'b0, 0, 0);    // RESET
        run_cmd(2, 0, 1'b0, 0, 0);    // READ illegal
        run_cmd(3, 0, 1'b0, 0, 0);    // BACK illegal
        run_cmd(0, 0, 1'b0, 0, 0);    // RESET while off
        run_cmd(1, 3, 1'b1, 2, 0);    // SET with valid held, READ queued
        run_cmd(2, 0, 1'b0, 0, 0);

        // Reset during PULSE
        cmd_op     = 2'd1;
        cmd_weight = 8'd20;
        cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pulse_before_rst", {9'b0, bl_set_en}, 10'd1);
        #1 rst = 1'b1;
        #1 check("async_rst_mid_pulse", obs_vec, 10'b0);
        @(negedge clk);
        rst = 1'b0;
        cell_on = 1'b0;
        @(negedge clk);
        check("ready_after_mid_rst", obs_vec, 10'b10_0000_0000);
        run_cmd(1, 2, 1'b0, 0, 0);    // SET raises wl again

        // Random commands
        for (int i = 0; i < NR; i++) begin
            rop[i] = int'($urandom_range(0, 3));
            rw[i]  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                 : int'($urandom_range(0, 10));
            rh[i]  = ($urandom_range(0, 3) == 0);
        end
        rh[NR-1] = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (i < NR - 1) run_cmd(rop[i], rw[i], rh[i], rop[i+1], rw[i+1]);
            else            run_cmd(rop[i], rw[i], 1'b0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
